muldiv_seq: RTL and testbench

Iterative multi-cycle multiply/divide unit and the parametrised successor to the single-cycle combinational ALU mul/div path. It computes signed and unsigned multiply and divide over WIDTH-bit operands, one bit per cycle. Results go to HI/LO outputs (MIPS convention) through a valid/ready handshake. It sits beside the ALU in EX; the pipeline stalls on busy and may abort an operation with flush.

---
 rtl/muldiv_seq.sv | 191 +++++++++++++++++++
 tb/tb_muldiv_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_seq
// Description : Iterative signed/unsigned multiply and divide, one bit per
//               cycle, with HI/LO results behind a valid/ready handshake.
//               Multiply is shift-add over operand magnitudes; divide is
//               restoring division. Signs are applied in a single fix-up
//               cycle after the iterations.
// Ports       : clk, rst                  clock, synchronous active-high reset
//               in_valid/in_ready, op,    request handshake, opcode
//               a, b                      (00 MULT 01 MULTU 10 DIV 11 DIVU)
//               flush                     abort in-flight operation
//               out_valid/out_ready       result handshake
//               hi, lo, div_zero          result (product or rem/quot)
//               busy                      iterating or fixing up
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero,
    output logic             busy
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_calc = 2'd1;
    localparam logic [1:0] c_st_fix  = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div;
    logic               r_sa;
    logic               r_sb;
    logic               r_dz;
    logic [WIDTH-1:0]   r_a_raw;
    logic [WIDTH-1:0]   r_ma;
    logic [WIDTH-1:0]   r_mb;
    logic [WIDTH-1:0]   r_rem;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide: low half shifts dividend bits out and quotient bits in.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_div_zero;

    logic               w_accept;
    logic               w_signed_op;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic               w_div_ge;
    logic [WIDTH-1:0]   w_rem_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_remf;
    logic [WIDTH-1:0]   w_hi_fix;
    logic [WIDTH-1:0]   w_lo_fix;
    logic               w_dz_fix;

    // flush in IDLE blocks the accept
    assign w_accept    = (r_state == c_st_idle) && in_valid && !flush;
    assign w_signed_op = ~op[0];
    // Negating the most negative value yields 2^(WIDTH-1) in unsigned view.
    assign w_abs_a     = (w_signed_op && a[WIDTH-1]) ? -a : a;
    assign w_abs_b     = (w_signed_op && b[WIDTH-1]) ? -b : b;

    // One shift-add step: add multiplicand if the current multiplier bit is 1.
    assign w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                         (r_acc[0] ? {1'b0, r_ma} : {(WIDTH+1){1'b0}});

    // One restoring step on a WIDTH+1-bit trial remainder.
    assign w_div_shift = {r_rem, r_acc[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_mb});
    assign w_rem_next  = w_div_ge ? WIDTH'(w_div_shift - {1'b0, r_mb})
                                  : w_div_shift[WIDTH-1:0];

    // Sign flags are latched as 0 for unsigned ops, so no op check needed.
    assign w_prod = (r_sa ^ r_sb) ? -r_acc : r_acc;
    assign w_quo  = (r_sa ^ r_sb) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_remf = r_sa ? -r_rem : r_rem;

    always_comb begin
        w_hi_fix = w_prod[2*WIDTH-1:WIDTH];
        w_lo_fix = w_prod[WIDTH-1:0];
        w_dz_fix = 1'b0;
        if (r_is_div) begin
            if (r_dz) begin
                w_hi_fix = r_a_raw;
                w_lo_fix = {WIDTH{1'b1}};
                w_dz_fix = 1'b1;
            end else begin
                w_hi_fix = w_remf;
                w_lo_fix = w_quo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (w_accept) w_state_next = c_st_calc;
            c_st_calc: begin
                if (flush)               w_state_next = c_st_idle;
                else if (r_cnt == '0)    w_state_next = c_st_fix;
            end
            c_st_fix:  w_state_next = flush ? c_st_idle : c_st_done;
            c_st_done: if (flush || out_ready) w_state_next = c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_sa       <= 1'b0;
            r_sb       <= 1'b0;
            r_dz       <= 1'b0;
            r_a_raw    <= '0;
            r_ma       <= '0;
            r_mb       <= '0;
            r_rem      <= '0;
            r_acc      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_div_zero <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt    <= CNT_W'(WIDTH - 1);
                r_is_div <= op[1];
                r_sa     <= w_signed_op & a[WIDTH-1];
                r_sb     <= w_signed_op & b[WIDTH-1];
                r_dz     <= op[1] && (b == '0);
                r_a_raw  <= a;
                r_ma     <= w_abs_a;
                r_mb     <= w_abs_b;
                r_rem    <= '0;
                r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_abs_a : w_abs_b)};
            end else if (r_state == c_st_calc) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - 1'b1;
                end
                if (r_is_div) begin
                    r_rem              <= w_rem_next;
                    r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], w_div_ge};
                end else begin
                    r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
                end
            end
            // Results commit only when FIX completes without an abort.
            if (r_state == c_st_fix && !flush) begin
                r_hi       <= w_hi_fix;
                r_lo       <= w_lo_fix;
                r_div_zero <= w_dz_fix;
            end
        end
    end

    assign in_ready  = (r_state == c_st_idle);
    assign out_valid = (r_state == c_st_done);
    assign busy      = (r_state == c_st_calc) || (r_state == c_st_fix);
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign div_zero  = r_div_zero;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_seq
// Description : Self-checking bench for muldiv_seq at WIDTH=32 and WIDTH=8,
//               directed cases plus random operations against an arithmetic
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  in_valid, flush, out_ready;
    logic [1:0]  op;
    logic [31:0] a_v, b_v;
    logic [1:0]  in_ready, out_valid, busy, div_zero;
    logic [31:0] hi32, lo32;
    logic [7:0]  hi8, lo8;

    int errors = 0;
    int checks = 0;

    muldiv_seq #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .op(op), .a(a_v), .b(b_v), .flush(flush[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .hi(hi32), .lo(lo32), .div_zero(div_zero[0]), .busy(busy[0])
    );

    muldiv_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .op(op), .a(a_v[7:0]), .b(b_v[7:0]), .flush(flush[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .hi(hi8), .lo(lo8), .div_zero(div_zero[1]), .busy(busy[1])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] hi_of(input int s);
        return (s == 0) ? hi32 : {24'd0, hi8};
    endfunction

    function automatic logic [31:0] lo_of(input int s);
        return (s == 0) ? lo32 : {24'd0, lo8};
    endfunction

    // Reference: plain integer arithmetic on w-bit operands.
    function automatic void model(input int w, input logic [1:0] o,
                                  input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] eh, output logic [31:0] el,
                                  output logic ed);
        logic [63:0] mask, ua, ub, p;
        longint      sx, sy, q, r;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, x} & mask;
        ub   = {32'd0, y} & mask;
        if (o[0] == 1'b0) begin
            sx = longint'(ua << (64 - w)) >>> (64 - w);
            sy = longint'(ub << (64 - w)) >>> (64 - w);
        end else begin
            sx = longint'(ua);
            sy = longint'(ub);
        end
        ed = 1'b0;
        if (o[1] == 1'b0) begin
            p  = 64'(sx * sy);
            eh = 32'((p >> w) & mask);
            el = 32'(p & mask);
        end else if (ub == 64'd0) begin
            ed = 1'b1;
            eh = 32'(ua);
            el = 32'(mask);
        end else begin
            q  = sx / sy;
            r  = sx % sy;
            eh = 32'(64'(r) & mask);
            el = 32'(64'(q) & mask);
        end
    endfunction

    // Issue one op on DUT s, wait for the result, check it and take it.
    task automatic run(input int s, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input string tag,
                       output logic [31:0] got_hi, output logic [31:0] got_lo);
        int          w, n;
        logic [31:0] eh, el;
        logic        ed;
        w = (s == 0) ? 32 : 8;
        op = o; a_v = x; b_v = y; in_valid[s] = 1'b1;
        @(posedge clk); #1;
        in_valid[s] = 1'b0;
        op = 2'($urandom); a_v = $urandom; b_v = $urandom;
        n = 1;
        check({tag, " busy"}, busy[s], 1);
        while (out_valid[s] !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, n, w + 2);
        model(w, o, x, y, eh, el, ed);
        check({tag, " hi"}, hi_of(s), eh);
        check({tag, " lo"}, lo_of(s), el);
        check({tag, " div_zero"}, div_zero[s], ed);
        got_hi = hi_of(s);
        got_lo = lo_of(s);
        out_ready[s] = 1'b1;
        @(posedge clk); #1;
        out_ready[s] = 1'b0;
        check({tag, " released"}, in_ready[s], 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] gh, gl, x, y;
        logic [1:0]  o;
        int          n;

        // Reset with in_valid asserted: nothing may be accepted.
        rst = 1'b1; in_valid = 2'b11; flush = 2'b00; out_ready = 2'b00;
        op = 2'b00; a_v = $urandom; b_v = $urandom;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", in_ready, 2'b11);
        check("reset out_valid", out_valid, 2'b00);
        check("reset busy", busy, 2'b00);
        check("reset hi", hi32, 0);
        check("reset lo", lo32, 0);
        check("reset div_zero", div_zero, 2'b00);
        in_valid = 2'b00; rst = 1'b0;
        @(posedge clk); #1;
        check("post reset idle", busy, 2'b00);

        // Directed arithmetic cases.
        run(0, 2'b00, 32'hFFFFFFFD, 32'h00000007, "mult", gh, gl);
        check("mult plan hi", gh, 32'hFFFFFFFF);
        check("mult plan lo", gl, 32'hFFFFFFEB);
        run(0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu", gh, gl);
        check("multu plan hi", gh, 32'hFFFFFFFE);
        check("multu plan lo", gl, 32'h00000001);
        run(0, 2'b11, 32'h00000064, 32'h00000007, "divu", gh, gl);
        check("divu plan hi", gh, 32'h00000002);
        check("divu plan lo", gl, 32'h0000000E);
        run(0, 2'b10, 32'hFFFFFFF9, 32'h00000002, "div", gh, gl);
        check("div plan hi", gh, 32'hFFFFFFFF);
        check("div plan lo", gl, 32'hFFFFFFFD);
        run(0, 2'b10, 32'h80000000, 32'hFFFFFFFF, "div minneg", gh, gl);
        check("div minneg hi", gh, 32'h00000000);
        check("div minneg lo", gl, 32'h80000000);
        run(0, 2'b11, 32'h00000064, 32'h00000000, "divu zero", gh, gl);
        check("divu zero hi", gh, 32'h00000064);
        check("divu zero lo", gl, 32'hFFFFFFFF);
        run(0, 2'b10, 32'hFFFFFFF9, 32'h00000000, "div zero", gh, gl);
        check("div zero hi", gh, 32'hFFFFFFF9);
        check("div zero lo", gl, 32'hFFFFFFFF);

        // Reset mid-operation clears the held result.
        op = 2'b11; a_v = 32'd100; b_v = 32'd7; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst hi", hi32, 0);
        check("midrst lo", lo32, 0);
        check("midrst div_zero", div_zero[0], 0);
        check("midrst in_ready", in_ready[0], 1);
        check("midrst busy", busy[0], 0);

        // Backpressure: result holds, extra requests are ignored.
        op = 2'b00; a_v = 32'd5; b_v = 32'd6; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        n = 1;
        while (out_valid[0] !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp latency", n, 34);
        repeat (10) begin
            @(posedge clk); #1;
            check("bp out_valid", out_valid[0], 1);
            check("bp hi", hi32, 32'd0);
            check("bp lo", lo32, 32'd30);
            check("bp in_ready", in_ready[0], 0);
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        check("no same-cycle accept", busy[0], 0);
        check("release in_ready", in_ready[0], 1);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        check("accept after release", busy[0], 1);

        // Flush at CALC cycle 5: abort, keep previous result.
        repeat (4) @(posedge clk);
        #1;
        flush[0] = 1'b1;
        @(posedge clk); #1;
        flush[0] = 1'b0;
        check("flush in_ready", in_ready[0], 1);
        check("flush busy", busy[0], 0);
        check("flush out_valid", out_valid[0], 0);
        check("flush hi kept", hi32, 32'd0);
        check("flush lo kept", lo32, 32'd30);

        // Flush in IDLE wins over in_valid.
        flush[0] = 1'b1; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        flush[0] = 1'b0; in_valid[0] = 1'b0;
        check("idle flush blocks accept", busy[0], 0);
        check("idle flush in_ready", in_ready[0], 1);

        // Random operations at WIDTH=32.
        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom);
            x = $urandom;
            y = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
            run(0, o, x, y, "rand32", gh, gl);
        end

        // WIDTH=8 instance.
        run(1, 2'b00, 32'h000000FD, 32'h00000007, "mult8", gh, gl);
        check("mult8 plan hi", gh, 32'h000000FF);
        check("mult8 plan lo", gl, 32'h000000EB);
        run(1, 2'b10, 32'h00000080, 32'h000000FF, "div8 minneg", gh, gl);
        check("div8 minneg lo", gl, 32'h00000080);
        for (int i = 0; i < 20; i++) begin
            o = 2'($urandom);
            x = $urandom;
            y = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
            run(1, o, x, y, "rand8", gh, gl);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
